// File: rtl/alu_rr_arbiter_if.sv
// Bundle of the two requester channels, the ALU operand/result bus and the
// tagged response channel that surround the round-robin ALU arbiter.
// The arbiter uses the slave view; the surrounding logic uses the master view.
interface alu_rr_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;
    logic [OPW-1:0]   req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;
    logic [OPW-1:0]   req1_op;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_cin;
    logic [OPW-1:0]   alu_op_sel;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_cout;
    logic             rsp_id;

    logic             busy;

    // Requesters, the ALU and the response consumer.
    modport master (
        output req0_valid, req0_a, req0_b, req0_cin, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_cin, alu_op_sel,
        output alu_result, alu_cout,
        input  rsp_valid, rsp_data, rsp_cout, rsp_id,
        output rsp_ready,
        input  busy
    );

    // The arbiter itself.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_cin, alu_op_sel,
        input  alu_result, alu_cout,
        output rsp_valid, rsp_data, rsp_cout, rsp_id,
        input  rsp_ready,
        output busy
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one registered ALU (1-cycle latency) between two
// requesters. One operation is in flight at a time:
// IDLE (accept) -> ISSUE (ALU computes) -> WAIT (capture) -> RESP (handshake).
module alu_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu_rr_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]       state_reg;
    logic             last_grant_reg;
    logic             tag_reg;
    logic [WIDTH-1:0] alu_a_reg;
    logic [WIDTH-1:0] alu_b_reg;
    logic             alu_cin_reg;
    logic [OPW-1:0]   alu_op_reg;
    logic             rsp_valid_reg;
    logic [WIDTH-1:0] rsp_data_reg;
    logic             rsp_cout_reg;
    logic             rsp_id_reg;

    logic             grant_valid;
    logic             grant_id;
    logic             accept;

    // Grant selection from the current-cycle valids; a tie goes to the
    // requester that was not served last.
    always_comb begin
        grant_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant_reg;
        end else begin
            grant_id = bus.req1_valid;
        end
    end

    // Gated by rst so that ready is forced low while reset is held, even with
    // the state already in IDLE.
    assign accept         = (state_reg == IDLE) && grant_valid && !rst;
    assign bus.req0_ready = accept && !grant_id;
    assign bus.req1_ready = accept && grant_id;
    assign bus.busy       = (state_reg != IDLE);

    assign bus.alu_a      = alu_a_reg;
    assign bus.alu_b      = alu_b_reg;
    assign bus.alu_cin    = alu_cin_reg;
    assign bus.alu_op_sel = alu_op_reg;
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_data   = rsp_data_reg;
    assign bus.rsp_cout   = rsp_cout_reg;
    assign bus.rsp_id     = rsp_id_reg;

    // Operation sequencing: latch operands on accept, capture the ALU result
    // one cycle after issue, hold the response until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            tag_reg        <= 1'b0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_cin_reg    <= 1'b0;
            alu_op_reg     <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_data_reg   <= '0;
            rsp_cout_reg   <= 1'b0;
            rsp_id_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        alu_a_reg      <= grant_id ? bus.req1_a   : bus.req0_a;
                        alu_b_reg      <= grant_id ? bus.req1_b   : bus.req0_b;
                        alu_cin_reg    <= grant_id ? bus.req1_cin : bus.req0_cin;
                        alu_op_reg     <= grant_id ? bus.req1_op  : bus.req0_op;
                        last_grant_reg <= grant_id;
                        tag_reg        <= grant_id;
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // ALU inputs are stable; the ALU registers on this edge.
                    state_reg <= WAIT;
                end
                WAIT: begin
                    rsp_data_reg  <= bus.alu_result;
                    rsp_cout_reg  <= bus.alu_cout;
                    rsp_id_reg    <= tag_reg;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                default: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter. A behavioural registered ALU sits
// on the ALU side; expectations come from transaction-level reasoning about
// grants, the 3-cycle response latency and the ALU function.
module tb_alu_rr_arbiter;
    localparam int WIDTH = 32;
    localparam int OPW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   exp_last = 1;

    alu_rr_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

    alu_rr_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: {cout, result} for each opcode.
    function automatic logic [32:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin);
        logic [63:0] p;
        case (op)
            4'd0:  alu_fn = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            4'd1:  alu_fn = {1'b0, a} - {1'b0, b} - {32'd0, cin};
            4'd2:  alu_fn = {1'b0, a & b};
            4'd3:  alu_fn = {1'b0, a | b};
            4'd4:  alu_fn = {1'b0, a ^ b};
            4'd5:  alu_fn = {1'b0, a} + 33'd1;
            4'd6:  alu_fn = {1'b0, a} - 33'd1;
            4'd7:  alu_fn = {1'b0, ~a};
            4'd8:  alu_fn = {a, cin};
            4'd9:  alu_fn = {a[0], cin, a[31:1]};
            4'd10: alu_fn = (b == 0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, a / b};
            4'd11: alu_fn = (b == 0) ? {1'b1, a} : {1'b0, a % b};
            4'd12: begin
                p = {32'd0, a} * {32'd0, b};
                alu_fn = {|p[63:32], p[31:0]};
            end
            4'd13: alu_fn = {1'b0, b};
            4'd14: alu_fn = {1'b0, ~(a & b)};
            default: alu_fn = {1'b0, a};
        endcase
    endfunction

    always @(posedge clk) begin
        {bus.alu_cout, bus.alu_result} <= alu_fn(bus.alu_op_sel, bus.alu_a, bus.alu_b, bus.alu_cin);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_cin = 0; bus.req0_op = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_cin = 0; bus.req1_op = 0;
        bus.rsp_ready = 0;
    endtask

    task automatic drive_req(input int id, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic cin, input logic v);
        if (id == 0) begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin; bus.req0_valid = v;
        end else begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin; bus.req1_valid = v;
        end
    endtask

    // Runs one operation from a single requester and reports what was observed.
    task automatic run_single(input int id, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic cin,
                              output logic [31:0] data, output logic cout, output logic rid,
                              output int lat, output logic [3:0] op_t1, output logic timed_out);
        int n;
        int t0;
        timed_out = 0; data = 'x; cout = 'x; rid = 'x; lat = -1; op_t1 = 'x;
        drive_req(id, op, a, b, cin, 1'b1);
        n = 0;
        #1;
        while (!((id == 0) ? bus.req0_ready : bus.req1_ready) && n < 20) begin
            tick(); #1; n++;
        end
        if (n >= 20) begin
            timed_out = 1;
            idle_inputs();
            tick();
            return;
        end
        t0 = cyc;
        exp_last = id;
        tick();
        if (id == 0) bus.req0_valid = 0; else bus.req1_valid = 0;
        #1;
        op_t1 = bus.alu_op_sel;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick(); #1; n++;
        end
        if (n >= 20) timed_out = 1;
        lat = cyc - t0;
        data = bus.rsp_data; cout = bus.rsp_cout; rid = bus.rsp_id;
        bus.rsp_ready = 1;
        tick();
        bus.rsp_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        bus.req0_valid = 1; bus.req1_valid = 1;
        tick(); tick(); #1;
        vectors++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            miscompares++; $display("FAIL reset_ready: got %b expected 00", {bus.req0_ready, bus.req1_ready});
        end
        vectors++;
        if ({bus.busy, bus.rsp_valid} !== 2'b00) begin
            miscompares++; $display("FAIL reset_busy_valid: got %b expected 00", {bus.busy, bus.rsp_valid});
        end
        vectors++;
        if ({bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_op_sel} !== '0) begin
            miscompares++; $display("FAIL reset_alu_regs: got a=%h b=%h cin=%b op=%h expected zeros",
                                    bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_op_sel);
        end
        vectors++;
        if ({bus.rsp_data, bus.rsp_cout, bus.rsp_id} !== '0) begin
            miscompares++; $display("FAIL reset_rsp_regs: got data=%h cout=%b id=%b expected zeros",
                                    bus.rsp_data, bus.rsp_cout, bus.rsp_id);
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        tick();
        rst = 0;
        exp_last = 1;
        #1;
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL post_reset_busy: got %b expected 0", bus.busy);
        end
        tick();
    endtask

    task automatic test_req0_add();
        logic [31:0] d; logic c; logic id; int lat; logic [3:0] op1; logic to;
        run_single(0, 4'd0, 32'd5, 32'd7, 1'b0, d, c, id, lat, op1, to);
        vectors++;
        if (to !== 1'b0) begin miscompares++; $display("FAIL req0_add_timeout: got %b expected 0", to); end
        vectors++;
        if (lat != 3) begin miscompares++; $display("FAIL req0_add_latency: got %0d expected 3", lat); end
        vectors++;
        if (op1 !== 4'd0) begin miscompares++; $display("FAIL req0_add_op_t1: got %h expected 0", op1); end
        vectors++;
        if ({c, d, id} !== {1'b0, 32'd12, 1'b0}) begin
            miscompares++; $display("FAIL req0_add_rsp: got cout=%b data=%h id=%b expected 0/0000000c/0", c, d, id);
        end
    endtask

    task automatic test_req1_add_sub();
        logic [31:0] d; logic c; logic id; int lat; logic [3:0] op1; logic to;
        run_single(1, 4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, d, c, id, lat, op1, to);
        vectors++;
        if ({to, c, d, id} !== {1'b0, 1'b1, 32'h0, 1'b1}) begin
            miscompares++; $display("FAIL req1_add_wrap: got to=%b cout=%b data=%h id=%b expected 0/1/00000000/1", to, c, d, id);
        end
        run_single(1, 4'd1, 32'd3, 32'd5, 1'b0, d, c, id, lat, op1, to);
        vectors++;
        if ({to, c, d, id} !== {1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1}) begin
            miscompares++; $display("FAIL req1_sub: got to=%b cout=%b data=%h id=%b expected 0/1/fffffffe/1", to, c, d, id);
        end
        vectors++;
        if (lat != 3) begin miscompares++; $display("FAIL req1_sub_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_round_robin();
        int exp_g; int prev_acc; int n_acc; int n_rsp; int got;
        logic exp_q[$];
        logic eid;
        drive_req(0, 4'd5, 32'd10, 32'd0, 1'b0, 1'b1);
        drive_req(1, 4'd6, 32'd10, 32'd0, 1'b0, 1'b1);
        bus.rsp_ready = 1;
        exp_g = 1 - exp_last; prev_acc = -1; n_acc = 0; n_rsp = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                got = bus.req1_ready ? 1 : 0;
                vectors++;
                if ((bus.req0_ready && bus.req1_ready) || got != exp_g) begin
                    miscompares++; $display("FAIL rr_grant: got ready=%b%b expected grant %0d", bus.req1_ready, bus.req0_ready, exp_g);
                end
                if (prev_acc >= 0) begin
                    vectors++;
                    if (cyc - prev_acc != 4) begin
                        miscompares++; $display("FAIL rr_interval: got %0d cycles expected 4", cyc - prev_acc);
                    end
                end
                prev_acc = cyc;
                exp_q.push_back(exp_g[0]);
                exp_last = exp_g;
                exp_g = 1 - exp_g;
                n_acc++;
            end
            if (bus.rsp_valid) begin
                eid = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
                vectors++;
                if ({bus.rsp_id, bus.rsp_data} !== {eid, (eid ? 32'd9 : 32'd11)}) begin
                    miscompares++; $display("FAIL rr_rsp: got id=%b data=%h expected id=%b data=%h",
                                            bus.rsp_id, bus.rsp_data, eid, (eid ? 32'd9 : 32'd11));
                end
                n_rsp++;
            end
            tick();
        end
        bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 0;
        vectors++;
        if (n_acc != 4 || n_rsp != 4) begin
            miscompares++; $display("FAIL rr_counts: got %0d accepts %0d responses expected 4 4", n_acc, n_rsp);
        end
    endtask

    task automatic test_backpressure();
        int g; int g2; int n;
        logic [32:0] e0; logic [32:0] e1; logic [32:0] e;
        logic [31:0] d; logic rid;
        drive_req(0, 4'd0, 32'd100, 32'd1, 1'b1, 1'b1);
        drive_req(1, 4'd4, 32'hF0, 32'h0F, 1'b0, 1'b1);
        e0 = alu_fn(4'd0, 32'd100, 32'd1, 1'b1);
        e1 = alu_fn(4'd4, 32'hF0, 32'h0F, 1'b0);
        bus.rsp_ready = 0;
        #1;
        g = bus.req1_ready ? 1 : 0;
        vectors++;
        if (!(bus.req0_ready ^ bus.req1_ready) || g != 1 - exp_last) begin
            miscompares++; $display("FAIL bp_first_grant: got ready=%b%b expected grant %0d", bus.req1_ready, bus.req0_ready, 1 - exp_last);
        end
        exp_last = g;
        e = g ? e1 : e0;
        tick();
        n = 0; #1;
        while (!bus.rsp_valid && n < 20) begin tick(); #1; n++; end
        vectors++;
        if ({bus.rsp_valid, bus.rsp_cout, bus.rsp_data, bus.rsp_id} !== {1'b1, e, g[0]}) begin
            miscompares++; $display("FAIL bp_first_rsp: got v=%b cout=%b data=%h id=%b expected 1/%b/%h/%0d",
                                    bus.rsp_valid, bus.rsp_cout, bus.rsp_data, bus.rsp_id, e[32], e[31:0], g);
        end
        d = bus.rsp_data; rid = bus.rsp_id;
        for (int k = 0; k < 5; k++) begin
            tick(); #1;
            vectors++;
            if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req0_ready, bus.req1_ready, bus.busy} !== {1'b1, d, rid, 2'b00, 1'b1}) begin
                miscompares++; $display("FAIL bp_hold: got v=%b data=%h id=%b rdy=%b%b busy=%b expected 1/%h/%b/00/1",
                                        bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req1_ready, bus.req0_ready, bus.busy, d, rid);
            end
        end
        bus.rsp_ready = 1;
        tick();
        bus.rsp_ready = 0;
        #1;
        g2 = 1 - exp_last;
        vectors++;
        if ({bus.req1_ready, bus.req0_ready} !== ((g2 == 1) ? 2'b10 : 2'b01)) begin
            miscompares++; $display("FAIL bp_release_grant: got ready=%b%b expected grant %0d", bus.req1_ready, bus.req0_ready, g2);
        end
        exp_last = g2;
        e = g2 ? e1 : e0;
        tick();
        bus.req0_valid = 0; bus.req1_valid = 0;
        n = 0; #1;
        while (!bus.rsp_valid && n < 20) begin tick(); #1; n++; end
        vectors++;
        if ({bus.rsp_valid, bus.rsp_cout, bus.rsp_data, bus.rsp_id} !== {1'b1, e, g2[0]}) begin
            miscompares++; $display("FAIL bp_second_rsp: got v=%b cout=%b data=%h id=%b expected 1/%b/%h/%0d",
                                    bus.rsp_valid, bus.rsp_cout, bus.rsp_data, bus.rsp_id, e[32], e[31:0], g2);
        end
        bus.rsp_ready = 1;
        tick();
        bus.rsp_ready = 0;
    endtask

    task automatic test_reset_midop();
        logic [31:0] d; logic c; logic id; int lat; logic [3:0] op1; logic to;
        drive_req(0, 4'd0, 32'd1, 32'd2, 1'b0, 1'b1);
        #1;
        vectors++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            miscompares++; $display("FAIL rmid_accept: got ready=%b%b expected grant 0", bus.req1_ready, bus.req0_ready);
        end
        exp_last = 0;
        tick();
        bus.req0_valid = 0;
        tick(); #1;
        vectors++;
        if ({bus.busy, bus.rsp_valid} !== 2'b10) begin
            miscompares++; $display("FAIL rmid_in_wait: got busy=%b v=%b expected 1/0", bus.busy, bus.rsp_valid);
        end
        rst = 1;
        #1;
        vectors++;
        if ({bus.rsp_valid, bus.busy, bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_op_sel} !== '0) begin
            miscompares++; $display("FAIL rmid_async_clear: got v=%b busy=%b a=%h b=%h cin=%b op=%h expected zeros",
                                    bus.rsp_valid, bus.busy, bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_op_sel);
        end
        tick();
        rst = 0;
        exp_last = 1;
        for (int k = 0; k < 6; k++) begin
            #1;
            vectors++;
            if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
                miscompares++; $display("FAIL rmid_no_rsp: got v=%b busy=%b expected 0/0", bus.rsp_valid, bus.busy);
            end
            tick();
        end
        // Tie probe without an accepting edge: last_grant came out of reset as 1.
        bus.req0_valid = 1; bus.req1_valid = 1;
        #1;
        vectors++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            miscompares++; $display("FAIL rmid_tie_after_reset: got ready=%b%b expected grant 0", bus.req1_ready, bus.req0_ready);
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        tick();
        run_single(1, 4'd15, 32'h1234, 32'd0, 1'b0, d, c, id, lat, op1, to);
        vectors++;
        if ({to, c, d, id} !== {1'b0, 1'b0, 32'h1234, 1'b1} || lat != 3) begin
            miscompares++; $display("FAIL rmid_pass: got to=%b cout=%b data=%h id=%b lat=%0d expected 0/0/00001234/1/3", to, c, d, id, lat);
        end
    endtask

    task automatic test_drop_valid();
        int n; logic bad0; logic [32:0] e;
        bad0 = 0;
        drive_req(1, 4'd3, 32'hA5A5, 32'h0F0F, 1'b0, 1'b1);
        #1;
        vectors++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
            miscompares++; $display("FAIL drop_first_accept: got ready=%b%b expected grant 1", bus.req1_ready, bus.req0_ready);
        end
        exp_last = 1;
        tick();
        drive_req(1, 4'd4, 32'hFF, 32'h0F, 1'b0, 1'b1);
        drive_req(0, 4'd0, 32'd1, 32'd1, 1'b0, 1'b1);
        bus.rsp_ready = 0;
        n = 0; #1;
        while (!bus.rsp_valid && n < 10) begin
            bad0 = bad0 | bus.req0_ready | bus.req1_ready;
            tick(); #1; n++;
        end
        e = alu_fn(4'd3, 32'hA5A5, 32'h0F0F, 1'b0);
        vectors++;
        if ({bus.rsp_valid, bus.rsp_cout, bus.rsp_data, bus.rsp_id} !== {1'b1, e, 1'b1}) begin
            miscompares++; $display("FAIL drop_first_rsp: got v=%b cout=%b data=%h id=%b expected 1/%b/%h/1",
                                    bus.rsp_valid, bus.rsp_cout, bus.rsp_data, bus.rsp_id, e[32], e[31:0]);
        end
        for (int k = 0; k < 2; k++) begin
            tick(); #1;
            bad0 = bad0 | bus.req0_ready | bus.req1_ready;
        end
        bus.rsp_ready = 1;
        bus.req0_valid = 0;
        #1;
        bad0 = bad0 | bus.req0_ready;
        tick();
        bus.rsp_ready = 0;
        #1;
        vectors++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
            miscompares++; $display("FAIL drop_regrant: got ready=%b%b expected grant 1", bus.req1_ready, bus.req0_ready);
        end
        exp_last = 1;
        tick();
        bus.req1_valid = 0;
        e = alu_fn(4'd4, 32'hFF, 32'h0F, 1'b0);
        n = 0; #1;
        while (!bus.rsp_valid && n < 20) begin
            bad0 = bad0 | bus.req0_ready;
            tick(); #1; n++;
        end
        vectors++;
        if ({bus.rsp_valid, bus.rsp_cout, bus.rsp_data, bus.rsp_id} !== {1'b1, e, 1'b1}) begin
            miscompares++; $display("FAIL drop_second_rsp: got v=%b cout=%b data=%h id=%b expected 1/%b/%h/1",
                                    bus.rsp_valid, bus.rsp_cout, bus.rsp_data, bus.rsp_id, e[32], e[31:0]);
        end
        bus.rsp_ready = 1;
        tick();
        bus.rsp_ready = 0;
        vectors++;
        if (bad0 !== 1'b0) begin
            miscompares++; $display("FAIL drop_req0_ready: got %b expected 0 (req0 never granted)", bad0);
        end
    endtask

    // Random valids, payloads and consumer back-pressure against a
    // transaction-level model: a single outstanding slot, response due three
    // cycles after accept, slot freed the cycle after the response handshake.
    task automatic test_random();
        logic free; int acc_cyc; logic [32:0] exp_res; logic exp_id;
        logic [31:0] pa [2]; logic [31:0] pb [2]; logic [3:0] pop [2]; logic pc [2]; logic v [2];
        logic [31:0] ea; logic [31:0] eb; logic [3:0] eop; logic ecin;
        logic eg_valid; logic eg; logic exp_rv;
        free = 1; acc_cyc = 0; exp_res = 0; exp_id = 0;
        ea = 0; eb = 0; eop = 0; ecin = 0;
        v[0] = 0; v[1] = 0;
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!v[r]) begin
                    pa[r]  = $urandom;
                    pb[r]  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                    pop[r] = 4'($urandom_range(0, 15));
                    pc[r]  = 1'($urandom_range(0, 1));
                end
                v[r] = ($urandom_range(0, 9) < 6);
                drive_req(r, pop[r], pa[r], pb[r], pc[r], v[r]);
            end
            bus.rsp_ready = 1'($urandom_range(0, 1));
            #1;
            eg_valid = free && (v[0] || v[1]);
            eg = (v[0] && v[1]) ? (exp_last == 0) : v[1];
            vectors++;
            if ({bus.req0_ready, bus.req1_ready} !== {eg_valid && !eg, eg_valid && eg}) begin
                miscompares++; $display("FAIL rand_ready: cyc %0d got %b%b expected %b%b", cyc,
                                        bus.req0_ready, bus.req1_ready, eg_valid && !eg, eg_valid && eg);
            end
            vectors++;
            if (bus.busy !== !free) begin
                miscompares++; $display("FAIL rand_busy: cyc %0d got %b expected %b", cyc, bus.busy, !free);
            end
            exp_rv = !free && (cyc - acc_cyc >= 3);
            vectors++;
            if (bus.rsp_valid !== exp_rv) begin
                miscompares++; $display("FAIL rand_rsp_valid: cyc %0d got %b expected %b", cyc, bus.rsp_valid, exp_rv);
            end
            if (exp_rv) begin
                vectors++;
                if ({bus.rsp_cout, bus.rsp_data, bus.rsp_id} !== {exp_res, exp_id}) begin
                    miscompares++; $display("FAIL rand_rsp: cyc %0d got cout=%b data=%h id=%b expected %b/%h/%b", cyc,
                                            bus.rsp_cout, bus.rsp_data, bus.rsp_id, exp_res[32], exp_res[31:0], exp_id);
                end
            end
            if (!free) begin
                vectors++;
                if ({bus.alu_op_sel, bus.alu_a, bus.alu_b, bus.alu_cin} !== {eop, ea, eb, ecin}) begin
                    miscompares++; $display("FAIL rand_alu_hold: cyc %0d got op=%h a=%h b=%h cin=%b expected %h/%h/%h/%b", cyc,
                                            bus.alu_op_sel, bus.alu_a, bus.alu_b, bus.alu_cin, eop, ea, eb, ecin);
                end
            end
            if (exp_rv && bus.rsp_ready) free = 1;
            if (eg_valid) begin
                free = 0; acc_cyc = cyc; exp_last = eg; exp_id = eg;
                eop = pop[eg]; ea = pa[eg]; eb = pb[eg]; ecin = pc[eg];
                exp_res = alu_fn(eop, ea, eb, ecin);
                v[eg] = 0;
            end
            tick();
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.rsp_ready = 1;
        repeat (6) tick();
        bus.rsp_ready = 0;
        #1;
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL rand_drain: got busy=%b expected 0", bus.busy);
        end
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_req0_add();
        test_req1_add_sub();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        test_drop_valid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one registered 32-bit ALU (1-cycle result latency, 4-bit op_sel, carry out) between two requesters.
- Uses round-robin arbitration with valid/ready handshakes on both requester channels and on a single tagged response channel.
- Sits between requester logic and the ALU. Drives the ALU operand/opcode inputs and captures its result and carry.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- OPW, 4, opcode width; must match the ALU op_sel.

Ports:
- clk  in  1  single clock, rising edge; the ALU uses the same clk.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_cin  in  1  requester 0 carry in.
- req0_op  in  OPW  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin, req1_op: same as requester 0, for requester 1.
- alu_a, alu_b  out  WIDTH  registered ALU operands.
- alu_cin  out  1  registered ALU carry in.
- alu_op_sel  out  OPW  registered ALU opcode.
- alu_result  in  WIDTH  ALU aluout.
- alu_cout  in  1  ALU cout.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  WIDTH  captured result.
- rsp_cout  out  1  captured carry.
- rsp_id  out  1  requester that owns the response.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: rst high forces, asynchronously:
  - state=IDLE, last_grant=1;
  - alu_a, alu_b, alu_cin, alu_op_sel = 0;
  - rsp_valid, rsp_data, rsp_cout, rsp_id = 0;
  - busy=0, req0_ready=req1_ready=0.
- Reset mid-operation discards the in-flight operation. No response is produced for it, and any ALU output arriving after reset is ignored.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. One operation is in flight at a time.
- IDLE, grant selection (combinational, from the current-cycle valids):
  - only req0_valid: grant 0.
  - only req1_valid: grant 1.
  - both valid: grant the requester that is not last_grant.
  - neither valid: no grant, stay IDLE.
- IDLE, accept: reqN_ready=1 only for the granted requester, and only in IDLE. It does not depend on rsp_ready.
- On the accept edge:
  - load alu_a/alu_b/alu_cin/alu_op_sel from the granted requester;
  - set last_grant=N and the internal tag=N;
  - go to ISSUE.
- ISSUE: ALU inputs held stable; the ALU registers its result on this cycle's closing edge. Go to WAIT.
- WAIT: alu_result/alu_cout are valid. On the closing edge, capture them into rsp_data/rsp_cout, set rsp_id=tag and rsp_valid=1, go to RESP.
- RESP: rsp_valid=1. rsp_data, rsp_cout and rsp_id are held stable until rsp_ready=1. On the edge with rsp_ready=1: rsp_valid=0, go to IDLE.
- ALU inputs are held through WAIT and RESP; they are not changed until the next accept.
- Latency: accept at cycle T gives rsp_valid=1 from cycle T+3. With rsp_ready tied high, the next accept is possible at T+4, so peak throughput is 1 operation per 4 cycles.
- Requesters hold valid and payload until ready. A valid that drops before ready is legal; arbitration is re-evaluated every IDLE cycle.
- A valid asserted while busy=1 waits; no reqN_ready is given outside IDLE.
- All 16 opcodes are passed through unmodified. Divide-by-zero and overflow results are returned exactly as the ALU produces them, with no flagging.
- Response width rules: rsp_data = alu_result[WIDTH-1:0], rsp_cout = alu_cout. No extension or masking.

Test Plan:
- After reset, req0 only, op 0000, a=5, b=7, cin=0 -> req0_ready at T, alu_op_sel=0000 at T+1, rsp_valid at T+3 with rsp_data=12, rsp_cout=0, rsp_id=0.
- req1 only, op 0000, a=0xFFFFFFFF, b=1 -> rsp_data=0x00000000, rsp_cout=1, rsp_id=1. Then op 0001, a=3, b=5 -> rsp_data=0xFFFFFFFE, rsp_cout=1.
- Both valid continuously, req0 op 0101 a=10 and req1 op 0110 a=10, rsp_ready=1 -> grants 0,1,0,1, accepts every 4 cycles, responses alternate 11 (id 0) and 9 (id 1).
- Hold rsp_ready=0 for 5 cycles in RESP with req0/req1 valid -> rsp_valid, rsp_data, rsp_id stable and both ready=0. Raise rsp_ready -> IDLE next cycle, then accept in that IDLE cycle.
- Assert rst during WAIT -> immediately rsp_valid=0, busy=0, alu_* = 0, no response after release. Then req1 only, op 1111, a=0x1234 -> granted, rsp_data=0x1234, rsp_id=1.
- Drop req0_valid in the cycle before IDLE while req1_valid stays high -> req1 granted, req0_ready never asserted.
